// File: rtl/bias_relu_if.sv
// Avalon-MM bus bundle: the master modport issues requests, the slave modport answers them.
// The block is a slave on its CPU port and a master on its SDRAM port.
interface bias_relu_if #(
  parameter int ADDR_W = 32
);
  logic              waitrequest;
  logic [ADDR_W-1:0] address;
  logic              read;
  logic [31:0]       readdata;
  logic              readdatavalid;
  logic              write;
  logic [31:0]       writedata;

  modport master (
    input  waitrequest, readdata, readdatavalid,
    output address, read, write, writedata
  );

  modport slave (
    input  address, read, write, writedata,
    output waitrequest, readdata
  );
endinterface

// File: rtl/bias_relu.sv
// Saturating Q16.16 bias add with optional ReLU over SDRAM vectors: dst[i] = relu(sat(dot[i] + bias[i])).
// CPU programs the addresses/length over the csr slave, then the FSM walks the vectors through the mem master.
module bias_relu #(
  parameter int WORD_BYTES = 4,
  parameter bit RELU_RESET = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  bias_relu_if.slave   csr,
  bias_relu_if.master  mem
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_SRC  = 3'd1;
  localparam logic [2:0] WT_SRC  = 3'd2;
  localparam logic [2:0] RD_BIAS = 3'd3;
  localparam logic [2:0] WT_BIAS = 3'd4;
  localparam logic [2:0] CALC    = 3'd5;
  localparam logic [2:0] WR      = 3'd6;
  localparam logic [2:0] FIN     = 3'd7;

  localparam logic [31:0] STRIDE = 32'(WORD_BYTES);

  logic [2:0]  state;
  logic [31:0] src_addr;
  logic [31:0] bias_addr;
  logic [31:0] dst_addr;
  logic [31:0] length;
  logic        relu;
  logic [31:0] sat_count;
  logic [31:0] idx;
  logic [31:0] a;
  logic [31:0] b;

  logic [31:0] offset;
  logic [32:0] sum;
  logic        clamp;
  logic [31:0] result;

  assign offset = idx * STRIDE;

  // NOTE: every signal assigned in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sum    = {a[31], a} + {b[31], b};
    clamp  = (sum[32] != sum[31]);
    result = sum[31:0];
    if (clamp) begin
      result = sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
    if (relu && result[31]) begin
      result = '0;
    end
  end

  // Readback is combinational; the CPU only samples it while the block is idle.
  always_comb begin
    csr.readdata = '0;
    case (csr.address)
      4'd0:    csr.readdata = sat_count;
      4'd2:    csr.readdata = src_addr;
      4'd3:    csr.readdata = bias_addr;
      4'd4:    csr.readdata = dst_addr;
      4'd5:    csr.readdata = length;
      4'd6:    csr.readdata = {31'b0, relu};
      default: csr.readdata = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      src_addr        <= '0;
      bias_addr       <= '0;
      dst_addr        <= '0;
      length          <= '0;
      relu            <= RELU_RESET;
      sat_count       <= '0;
      idx             <= '0;
      a               <= '0;
      b               <= '0;
      mem.read        <= 1'b0;
      mem.write       <= 1'b0;
      mem.address     <= '0;
      mem.writedata   <= '0;
      csr.waitrequest <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (csr.write) begin
            case (csr.address)
              4'd0: begin
                sat_count       <= '0;
                idx             <= '0;
                csr.waitrequest <= 1'b1;
                state           <= RD_SRC;
              end
              4'd2:    src_addr  <= csr.writedata;
              4'd3:    bias_addr <= csr.writedata;
              4'd4:    dst_addr  <= csr.writedata;
              4'd5:    length    <= csr.writedata;
              4'd6:    relu      <= csr.writedata[0];
              default: ;
            endcase
          end
        end

        // First cycle decides between finishing and issuing; the request then holds until accepted.
        RD_SRC: begin
          if (!mem.read) begin
            if (idx >= length) begin
              state <= FIN;
            end else begin
              mem.read    <= 1'b1;
              mem.address <= src_addr + offset;
            end
          end else if (!mem.waitrequest) begin
            mem.read <= 1'b0;
            state    <= WT_SRC;
          end
        end

        // The bias request is launched together with capturing the source word to save a cycle.
        WT_SRC: begin
          if (mem.readdatavalid) begin
            a           <= mem.readdata;
            mem.read    <= 1'b1;
            mem.address <= bias_addr + offset;
            state       <= RD_BIAS;
          end
        end

        RD_BIAS: begin
          if (!mem.waitrequest) begin
            mem.read <= 1'b0;
            state    <= WT_BIAS;
          end
        end

        WT_BIAS: begin
          if (mem.readdatavalid) begin
            b     <= mem.readdata;
            state <= CALC;
          end
        end

        CALC: begin
          mem.writedata <= result;
          mem.write     <= 1'b1;
          mem.address   <= dst_addr + offset;
          if (clamp) begin
            sat_count <= sat_count + 32'd1;
          end
          state <= WR;
        end

        WR: begin
          if (!mem.waitrequest) begin
            mem.write <= 1'b0;
            idx       <= idx + 32'd1;
            state     <= RD_SRC;
          end
        end

        FIN: begin
          csr.waitrequest <= 1'b0;
          state           <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bias_relu.sv
// Directed bench for bias_relu: an SDRAM responder at the falling edge plus one task per scenario,
// each comparing memory contents, bus traffic and CSR readback against hand-computed values.
module tb_bias_relu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bias_relu_if #(.ADDR_W(4))  csr ();
  bias_relu_if #(.ADDR_W(32)) mem ();

  bias_relu #(.WORD_BYTES(4), .RELU_RESET(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .csr   (csr),
    .mem   (mem)
  );

  int errors = 0;
  int checks = 0;

  bit [31:0] sdram [bit [31:0]];
  bit        bp_en = 1'b0;
  int        rd_count, wr_count, strobes, viol;
  bit [31:0] rd_log [$];
  bit [31:0] wr_log [$];

  bit        pending = 1'b0;
  int        delay_cnt;
  bit [31:0] pend_addr;
  bit        prev_held = 1'b0;
  logic [31:0] prev_addr, prev_data;
  logic        prev_rd, prev_wr;

  // SDRAM model: decides waitrequest for the next edge, logs accepted requests, returns read data.
  initial begin
    mem.waitrequest   = 1'b0;
    mem.readdata      = '0;
    mem.readdatavalid = 1'b0;
    csr.readdatavalid = 1'b0;
    forever begin
      @(negedge clk);
      mem.readdatavalid = 1'b0;
      if (!rst_n) begin
        pending   = 1'b0;
        prev_held = 1'b0;
      end
      if (pending) begin
        if (delay_cnt == 0) begin
          mem.readdatavalid = 1'b1;
          mem.readdata      = sdram.exists(pend_addr) ? sdram[pend_addr] : 32'hDEAD_BEEF;
          pending           = 1'b0;
        end else begin
          delay_cnt--;
        end
      end
      if (prev_held && rst_n && (mem.read !== prev_rd || mem.write !== prev_wr ||
          mem.address !== prev_addr || (prev_wr && mem.writedata !== prev_data))) viol++;
      if (mem.read === 1'b1 && mem.write === 1'b1) viol++;
      if (mem.read === 1'b1 || mem.write === 1'b1) strobes++;
      mem.waitrequest = bp_en ? 1'($urandom_range(0, 1)) : 1'b0;
      if (mem.read === 1'b1 && !mem.waitrequest) begin
        rd_count++;
        rd_log.push_back(mem.address);
        if (pending) viol++;
        pending   = 1'b1;
        pend_addr = mem.address;
        delay_cnt = bp_en ? int'($urandom_range(0, 5)) : 0;
      end
      if (mem.write === 1'b1 && !mem.waitrequest) begin
        wr_count++;
        wr_log.push_back(mem.address);
        sdram[mem.address] = mem.writedata;
      end
      prev_held = (mem.read === 1'b1 || mem.write === 1'b1) && mem.waitrequest;
      prev_rd   = mem.read;
      prev_wr   = mem.write;
      prev_addr = mem.address;
      prev_data = mem.writedata;
    end
  end

  task automatic clear_monitor();
    rd_count = 0;
    wr_count = 0;
    strobes  = 0;
    viol     = 0;
    rd_log.delete();
    wr_log.delete();
  endtask

  task automatic csr_write(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    csr.address   = addr;
    csr.writedata = data;
    csr.write     = 1'b1;
    @(negedge clk);
    csr.write     = 1'b0;
  endtask

  task automatic csr_read(input logic [3:0] addr, output logic [31:0] data);
    @(negedge clk);
    csr.address = addr;
    csr.read    = 1'b1;
    #1;
    data        = csr.readdata;
    csr.read    = 1'b0;
  endtask

  task automatic load_vectors(input bit [31:0] sb, input bit [31:0] bb, input bit [31:0] db,
                              input bit [31:0] s [4], input bit [31:0] b [4]);
    for (int i = 0; i < 4; i++) begin
      sdram[sb + 32'(4 * i)] = s[i];
      sdram[bb + 32'(4 * i)] = b[i];
      sdram[db + 32'(4 * i)] = 32'hAAAA_AAAA;
    end
  endtask

  // Programs the registers, starts the block and counts cycles with slave waitrequest high.
  task automatic do_run(input bit [31:0] sb, input bit [31:0] bb, input bit [31:0] db,
                        input bit [31:0] len, input bit relu, output int high);
    bit ok;
    csr_write(4'd2, sb);
    csr_write(4'd3, bb);
    csr_write(4'd4, db);
    csr_write(4'd5, len);
    csr_write(4'd6, {31'b0, relu});
    clear_monitor();
    csr_write(4'd0, 32'h0);
    high = 0;
    ok   = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      if (csr.waitrequest === 1'b1) begin
        high++;
        @(negedge clk);
      end else begin
        ok = 1'b1;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL run_timeout: waitrequest still %b after %0d cycles, required 0", csr.waitrequest, high);
    end
  endtask

  bit [31:0] basic_src  [4] = '{32'h0001_0000, 32'hFFFF_0000, 32'h0002_8000, 32'h0000_0000};
  bit [31:0] basic_bias [4] = '{32'h0000_8000, 32'h0000_8000, 32'hFFFF_8000, 32'h0000_0000};

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] exp_rd [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1};
    checks++;
    if (csr.waitrequest !== 1'b0) begin
      errors++; $display("FAIL reset_slave_wait: got %b required 0", csr.waitrequest);
    end
    checks++;
    if (mem.read !== 1'b0 || mem.write !== 1'b0) begin
      errors++; $display("FAIL reset_strobes: got rd=%b wr=%b required 0 0", mem.read, mem.write);
    end
    checks++;
    if (mem.address !== 32'h0 || mem.writedata !== 32'h0) begin
      errors++; $display("FAIL reset_addr_data: got %h/%h required 0/0", mem.address, mem.writedata);
    end
    for (int i = 0; i < 7; i++) begin
      if (i == 1) continue;
      csr_read(4'(i), rd);
      checks++;
      if (rd !== exp_rd[i]) begin
        errors++; $display("FAIL reset_reg%0d: got %h required %h", i, rd, exp_rd[i]);
      end
    end
  endtask

  task automatic test_basic();
    int high;
    logic [31:0] rd;
    bit [31:0] exp_dst [3] = '{32'h0001_8000, 32'hFFFF_8000, 32'h0002_0000};
    bit [31:0] exp_rd  [6] = '{32'h1000, 32'h2000, 32'h1004, 32'h2004, 32'h1008, 32'h2008};
    load_vectors(32'h1000, 32'h2000, 32'h3000, basic_src, basic_bias);
    do_run(32'h1000, 32'h2000, 32'h3000, 32'd3, 1'b0, high);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sdram[32'h3000 + 32'(4 * i)] !== exp_dst[i]) begin
        errors++; $display("FAIL basic_dst%0d: got %h required %h", i, sdram[32'h3000 + 32'(4 * i)], exp_dst[i]);
      end
    end
    checks++;
    if (rd_count !== 6 || wr_count !== 3) begin
      errors++; $display("FAIL basic_traffic: got %0d reads %0d writes required 6 and 3", rd_count, wr_count);
    end
    for (int i = 0; i < 6 && i < rd_log.size(); i++) begin
      checks++;
      if (rd_log[i] !== exp_rd[i]) begin
        errors++; $display("FAIL basic_rd_addr%0d: got %h required %h", i, rd_log[i], exp_rd[i]);
      end
    end
    for (int i = 0; i < 3 && i < wr_log.size(); i++) begin
      checks++;
      if (wr_log[i] !== 32'h3000 + 32'(4 * i)) begin
        errors++; $display("FAIL basic_wr_addr%0d: got %h required %h", i, wr_log[i], 32'h3000 + 32'(4 * i));
      end
    end
    csr_read(4'd0, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++; $display("FAIL basic_sat_count: got %0d required 0", rd);
    end
    csr_read(4'd4, rd);
    checks++;
    if (rd !== 32'h3000) begin
      errors++; $display("FAIL basic_dst_reg: got %h required 00003000", rd);
    end
  endtask

  task automatic test_relu();
    int high;
    bit [31:0] exp_dst [3] = '{32'h0001_8000, 32'h0000_0000, 32'h0002_0000};
    load_vectors(32'h1000, 32'h2000, 32'h4000, basic_src, basic_bias);
    do_run(32'h1000, 32'h2000, 32'h4000, 32'd3, 1'b1, high);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sdram[32'h4000 + 32'(4 * i)] !== exp_dst[i]) begin
        errors++; $display("FAIL relu_dst%0d: got %h required %h", i, sdram[32'h4000 + 32'(4 * i)], exp_dst[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int high;
    logic [31:0] rd;
    bit [31:0] s [4] = '{32'h7FFF_0000, 32'h8000_0000, 32'h0, 32'h0};
    bit [31:0] b [4] = '{32'h0002_0000, 32'hFFFF_FFFF, 32'h0, 32'h0};
    bit [31:0] exp_dst [2] = '{32'h7FFF_FFFF, 32'h8000_0000};
    load_vectors(32'h6000, 32'h6100, 32'h6200, s, b);
    do_run(32'h6000, 32'h6100, 32'h6200, 32'd2, 1'b0, high);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (sdram[32'h6200 + 32'(4 * i)] !== exp_dst[i]) begin
        errors++; $display("FAIL sat_dst%0d: got %h required %h", i, sdram[32'h6200 + 32'(4 * i)], exp_dst[i]);
      end
    end
    csr_read(4'd0, rd);
    checks++;
    if (rd !== 32'd2) begin
      errors++; $display("FAIL sat_count: got %0d required 2", rd);
    end
  endtask

  task automatic test_back_pressure();
    int high;
    bit [31:0] exp_dst [3] = '{32'h0001_8000, 32'hFFFF_8000, 32'h0002_0000};
    load_vectors(32'h1000, 32'h2000, 32'h5000, basic_src, basic_bias);
    bp_en = 1'b1;
    do_run(32'h1000, 32'h2000, 32'h5000, 32'd3, 1'b0, high);
    bp_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sdram[32'h5000 + 32'(4 * i)] !== exp_dst[i]) begin
        errors++; $display("FAIL bp_dst%0d: got %h required %h", i, sdram[32'h5000 + 32'(4 * i)], exp_dst[i]);
      end
    end
    checks++;
    if (viol !== 0) begin
      errors++; $display("FAIL bp_bus_rules: got %0d violations required 0", viol);
    end
    checks++;
    if (rd_count !== 6 || wr_count !== 3) begin
      errors++; $display("FAIL bp_traffic: got %0d reads %0d writes required 6 and 3", rd_count, wr_count);
    end
  endtask

  task automatic test_length_zero();
    int high;
    do_run(32'h1000, 32'h2000, 32'h7000, 32'd0, 1'b0, high);
    repeat (3) @(negedge clk);
    checks++;
    if (high !== 2) begin
      errors++; $display("FAIL len0_wait_cycles: got %0d required 2", high);
    end
    checks++;
    if (strobes !== 0) begin
      errors++; $display("FAIL len0_traffic: got %0d strobe cycles required 0", strobes);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] rd;
    bit found = 1'b0;
    bit [31:0] s [4] = '{32'h1, 32'h2, 32'h3, 32'h4};
    bit [31:0] b [4] = '{32'h10, 32'h20, 32'h30, 32'h40};
    load_vectors(32'h8000, 32'h8100, 32'h8200, s, b);
    csr_write(4'd2, 32'h8000);
    csr_write(4'd3, 32'h8100);
    csr_write(4'd4, 32'h8200);
    csr_write(4'd5, 32'd4);
    csr_write(4'd6, 32'd0);
    csr_write(4'd0, 32'd0);
    for (int i = 0; i < 200 && !found; i++) begin
      #1;
      if (mem.write === 1'b1 && mem.address === 32'h8204) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL rst_mid_reach_wr1: got no write to %h required one", 32'h8204);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (mem.read !== 1'b0 || mem.write !== 1'b0 || csr.waitrequest !== 1'b0) begin
      errors++; $display("FAIL rst_mid_outputs: got rd=%b wr=%b wait=%b required 0 0 0",
                         mem.read, mem.write, csr.waitrequest);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      csr_read(4'(i), rd);
      checks++;
      if (rd !== 32'h0) begin
        errors++; $display("FAIL rst_mid_reg%0d: got %h required 0", i, rd);
      end
    end
    csr_read(4'd6, rd);
    checks++;
    if (rd[0] !== 1'b1) begin
      errors++; $display("FAIL rst_mid_relu: got %b required 1", rd[0]);
    end
  endtask

  initial begin
    csr.address   = '0;
    csr.read      = 1'b0;
    csr.write     = 1'b0;
    csr.writedata = '0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_relu();
    test_saturation();
    test_back_pressure();
    test_length_zero();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
